// File: rtl/rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 8-state RSC encoder: ACS over K+3 symbols, traceback from state 0, K bits out.
// Optional RSC_VITERBI_METRIC_OUT_EN adds final_metric, the path metric of the chosen path.
module rsc_viterbi_decoder #(
  parameter int K    = 40,
  parameter int PM_W = 8
) (
  input  logic clock,
  input  logic aclr,
  input  logic start,
  input  logic in_valid,
  input  logic x_in,
  input  logic z_in,
  output logic busy,
  output logic out_valid,
  output logic c_out,
  output logic out_last
`ifdef RSC_VITERBI_METRIC_OUT_EN
  ,
  output logic [PM_W-1:0] final_metric
`endif
);

  localparam int NSYM = K + 3;
  localparam int CW   = $clog2(NSYM + 1);
  localparam int KW   = $clog2(K);
  localparam logic [PM_W-1:0] PM_INIT = {1'b1, {(PM_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACS, TRACE, EMIT} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [PM_W-1:0] pm     [8];
  logic [PM_W-1:0] pm_nxt [8];
  logic [PM_W-1:0] cand0  [8];
  logic [PM_W-1:0] cand1  [8];
  logic [7:0]      acs_surv;
  logic [7:0]      surv   [NSYM];
  logic [2:0]      tb_state;
  logic            tb_p;
  logic            tb_u;
  logic [K-1:0]    dec;
  logic            tail_step;

  // Hamming distance between received (x,z) and the branch into n from predecessor {n[1],n[0],p}.
  function automatic logic [1:0] branch_metric(logic [2:0] n, logic p, logic x, logic z);
    logic u, ze;
    u  = n[2] ^ p ^ n[0];
    ze = u ^ n[0] ^ n[1];
    return {1'b0, x ^ u} + {1'b0, z ^ ze};
  endfunction

  function automatic logic [PM_W-1:0] sat_add(logic [PM_W-1:0] a, logic [1:0] b);
    logic [PM_W:0] s;
    s = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return s[PM_W] ? '1 : s[PM_W-1:0];
  endfunction

  assign tail_step = (cnt >= CW'(K));

  // NOTE: every variable assigned in a combinational block gets a value on every path, so no latch is inferred.
  always_comb begin
    acs_surv = '0;
    for (int i = 0; i < 8; i++) begin
      cand0[i]    = sat_add(pm[2*(i%4)],     branch_metric(3'(i), 1'b0, x_in, z_in));
      cand1[i]    = sat_add(pm[2*(i%4) + 1], branch_metric(3'(i), 1'b1, x_in, z_in));
      acs_surv[i] = (cand1[i] < cand0[i]);
      pm_nxt[i]   = acs_surv[i] ? cand1[i] : cand0[i];
      if (tail_step && i >= 4) pm_nxt[i] = '1;
    end
  end

  assign tb_p = surv[cnt][tb_state];
  assign tb_u = tb_state[2] ^ tb_p ^ tb_state[0];

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    out_valid = 1'b0;
    c_out     = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ACS;
      ACS:   if (cnt == CW'(NSYM)) state_nxt = TRACE;
      TRACE: if (cnt == '0) state_nxt = EMIT;
      EMIT: begin
        out_valid = 1'b1;
        c_out     = dec[0];
        out_last  = (cnt == CW'(K - 1));
        if (out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the survivor memory is reset along with the metrics so a block can never trace through stale rows.
  always_ff @(posedge clock or posedge aclr) begin
    if (aclr) begin
      for (int i = 0; i < 8; i++) pm[i] <= '0;
      for (int t = 0; t < NSYM; t++) surv[t] <= '0;
      cnt      <= '0;
      tb_state <= '0;
      dec      <= '0;
`ifdef RSC_VITERBI_METRIC_OUT_EN
      final_metric <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          pm[0] <= '0;
          for (int i = 1; i < 8; i++) pm[i] <= PM_INIT;
          cnt <= '0;
        end
        ACS: begin
          // One idle cycle after the last tail symbol lets the metrics settle before traceback.
          if (cnt == CW'(NSYM)) begin
            cnt      <= CW'(NSYM - 1);
            tb_state <= '0;
`ifdef RSC_VITERBI_METRIC_OUT_EN
            final_metric <= pm[0];
`endif
          end else if (in_valid) begin
            for (int i = 0; i < 8; i++) pm[i] <= pm_nxt[i];
            surv[cnt] <= acs_surv;
            cnt       <= cnt + 1'b1;
          end
        end
        TRACE: begin
          if (cnt < CW'(K)) dec[cnt[KW-1:0]] <= tb_u;
          tb_state <= {tb_state[1:0], tb_p};
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        EMIT: begin
          dec <= dec >> 1;
          cnt <= (cnt == CW'(K - 1)) ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsc_viterbi_decoder.sv
// Directed bench for rsc_viterbi_decoder (K=40): encodes known patterns, injects errors/gaps/resets, checks decoded output.
module tb_rsc_viterbi_decoder;

  localparam int K    = 40;
  localparam int PM_W = 8;
  localparam int NSYM = K + 3;

  logic clock = 1'b0;
  logic aclr  = 1'b1;
  logic start = 1'b0;
  logic in_valid = 1'b0;
  logic x_in = 1'b0;
  logic z_in = 1'b0;
  logic busy, out_valid, c_out, out_last;
`ifdef RSC_VITERBI_METRIC_OUT_EN
  logic [PM_W-1:0] final_metric;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  localparam logic [K-1:0] PATTERN = 40'hA5_3C_0F_96_E1;

  rsc_viterbi_decoder #(.K(K), .PM_W(PM_W)) dut (
    .clock     (clock),
    .aclr      (aclr),
    .start     (start),
    .in_valid  (in_valid),
    .x_in      (x_in),
    .z_in      (z_in),
    .busy      (busy),
    .out_valid (out_valid),
    .c_out     (c_out),
    .out_last  (out_last)
`ifdef RSC_VITERBI_METRIC_OUT_EN
    ,
    .final_metric (final_metric)
`endif
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic run_block(input string tag, input logic [K-1:0] info, input int flip_z,
                           input int flip_x, input bit gaps, input bit mid_start, input int exp_metric);
    logic       sx [NSYM];
    logic       sz [NSYM];
    logic [2:0] s;
    logic       u;
    logic [K-1:0] got;
    int last_cyc, first_cyc, last_pos, nv, w;

    // Reference encoder: information bits then three terminating tail steps.
    s = 3'b000;
    for (int i = 0; i < NSYM; i++) begin
      u     = (i < K) ? info[i] : (s[0] ^ s[1]);
      sx[i] = u;
      sz[i] = u ^ s[1] ^ s[2];
      s     = {u ^ s[0] ^ s[1], s[2], s[1]};
    end

    w = 0;
    while (busy && w < 200) begin
      @(posedge clock);
      w++;
    end
    check({tag, "_idle_before"}, busy, 1'b0);

    @(posedge clock); #1;
    start = 1'b1; in_valid = 1'b1; x_in = 1'b1; z_in = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; in_valid = 1'b0;

    last_cyc = 0;
    for (int i = 0; i < NSYM; i++) begin
      x_in = sx[i] ^ (i == flip_x);
      z_in = sz[i] ^ (i == flip_z);
      in_valid = 1'b1;
      if (mid_start && i == 20) start = 1'b1;
      @(posedge clock); #1;
      if (i == NSYM - 1) last_cyc = cyc;
      in_valid = 1'b0; start = 1'b0;
      if (mid_start && i == 20) check({tag, "_busy_mid"}, busy, 1'b1);
      if (gaps && i < NSYM - 1) begin
        x_in = 1'b1; z_in = 1'b1;
        @(posedge clock); #1;
      end
    end

    got = '0; nv = 0; first_cyc = -1; last_pos = -1;
    for (int c = 0; c < 130; c++) begin
      @(negedge clock);
      if (out_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (nv < K) got[nv] = c_out;
        if (out_last) last_pos = nv;
        nv++;
      end
    end

    check({tag, "_bits"}, got, info);
    check({tag, "_nvalid"}, nv, K);
    check({tag, "_last_pos"}, last_pos, K - 1);
    check({tag, "_latency"}, first_cyc - last_cyc, K + 4);
    check({tag, "_busy_after"}, busy, 1'b0);
`ifdef RSC_VITERBI_METRIC_OUT_EN
    check({tag, "_metric"}, final_metric, exp_metric);
`else
    if (exp_metric < 0) check({tag, "_metric_arg"}, exp_metric, 0);
`endif
  endtask

  initial begin
    #2;
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_c_out", c_out, 1'b0);
    check("rst_out_last", out_last, 1'b0);
`ifdef RSC_VITERBI_METRIC_OUT_EN
    check("rst_metric", final_metric, 0);
`endif
    @(posedge clock); #1;
    aclr = 1'b0;

    run_block("s1_zero",     '0,      -1, -1, 1'b0, 1'b0, 0);
    run_block("s2_pattern",  PATTERN, -1, -1, 1'b0, 1'b0, 0);
    run_block("s3_zflip10",  PATTERN, 10, -1, 1'b0, 1'b0, 1);
    run_block("s4_gaps",     PATTERN, -1, -1, 1'b1, 1'b1, 0);

    // Abort a block after 20 symbols with an asynchronous reset.
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; x_in = PATTERN[i]; z_in = 1'b0;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    check("s5_busy_pre", busy, 1'b1);
    aclr = 1'b1;
    #1;
    check("s5_busy_rst", busy, 1'b0);
    check("s5_valid_rst", out_valid, 1'b0);
    @(posedge clock); #1;
    aclr = 1'b0;
    run_block("s5_after_rst", PATTERN, -1, -1, 1'b0, 1'b0, 0);

    run_block("s6_xflip41",  PATTERN, -1, 41, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rsc_viterbi_decoder.md
Name: rsc_viterbi_decoder

Overview:
- Hard-decision Viterbi decoder for the team's 8-state recursive systematic constituent encoder. Decodes one tail-terminated block of K information bits per run.
- Accepts K+3 (x,z) symbol pairs, runs add-compare-select, performs traceback from state 0, then emits the K decoded bits in original order.
- Used as the receive-side loopback and check path for the encoder block.

Parameters:
K, 40, information bits per block; legal range 8..120.
PM_W, 8, path-metric width in bits; must satisfy 2^(PM_W-1) > 2*(K+3).

Ports:
clock  input  1  system clock, rising edge
aclr  input  1  reset, asynchronous, active-high
start  input  1  begin a new block; honoured only in IDLE
in_valid  input  1  x_in and z_in are valid this cycle
x_in  input  1  received systematic bit
z_in  input  1  received parity bit
busy  output  1  high in every state except IDLE
out_valid  output  1  c_out is valid this cycle
c_out  output  1  decoded information bit
out_last  output  1  high together with the K-th out_valid

Behaviour:
- Encoder trellis. State s = {d2,d1,d0}. For input bit u:
  - next state = {u^d0^d1, d2, d1}
  - outputs x = u, z = u^d1^d2
  - Tail steps use u = d0^d1, which forces next-state d2 = 0. Three tail steps reach state 0 from any state.
- Reset: busy, out_valid, c_out and out_last are 0. FSM is IDLE. All metrics, survivor memory and counters are 0.
- FSM states: IDLE, ACS, TRACE, EMIT.
- IDLE -> ACS:
  - Triggered by start=1.
  - PM[0] loads 0; PM[1..7] load 2^(PM_W-1).
  - Symbol counter loads 0.
  - in_valid asserted in the same cycle as start is ignored.
- ACS:
  - Each cycle with in_valid=1 consumes one symbol. in_valid=0 holds all state; gaps are arbitrary.
  - Branch metric = Hamming distance between (x_in,z_in) and the transition's expected (x,z), range 0..2.
  - Each next state n has two predecessors: {n[1], n[0], p}, p in {0,1}.
  - Candidate metric = PM[pred] + BM. Keep the smaller; on a tie, take p=0.
  - Write survivor bit p into survivor memory row t, where t is the symbol index.
  - Symbols 0..K-1 are information steps. Symbols K..K+2 are tail steps: next states with d2=1 are loaded with the all-ones metric (invalid).
  - Metric additions saturate at all-ones.
  - After symbol K+2 is consumed, go to TRACE on the next edge.
- TRACE:
  - Lasts exactly K+3 cycles, stepping t from K+2 down to 0.
  - Starts in state 0.
  - For current state s' at step t, with p = survivor[t][s']:
    - decoded bit u = s'[2] ^ p ^ s'[0]
    - previous state = {s'[1], s'[0], p}
  - u is written to bit t of the output register only for t < K.
  - Then go to EMIT.
- EMIT:
  - out_valid=1 for exactly K consecutive cycles.
  - c_out = bit 0 first, through bit K-1.
  - out_last=1 on bit K-1.
  - Then return to IDLE with out_valid, c_out and out_last at 0.
- Latency: the last tail symbol is accepted at edge n; the first out_valid cycle is the one following edge n+K+4.
- Ignored inputs:
  - start while busy=1.
  - in_valid outside ACS.
- Reset mid-operation: aclr at any point returns immediately to reset values. The partial block is discarded, and the next start decodes cleanly.
- No backpressure on outputs; the consumer must accept one bit per cycle during EMIT.

Optional Feature:
- Macro: RSC_VITERBI_METRIC_OUT_EN.
- Defined:
  - Adds output final_metric, PM_W bits.
  - At the TRACE entry edge it captures PM[0] after the final tail step, i.e. the Hamming distance of the chosen path.
  - Holds that value until the next start; reset value 0.
- Undefined: the port and capture register are absent; all other behaviour is identical.

Test Plan (K=40):
1. start, then 43 symbols (0,0), in_valid continuous -> 40 out_valid cycles with c_out=0; out_last on cycle 40; busy returns 0; final_metric=0.
2. Information bits 40'hA5_3C_0F_96_E1 (LSB first) encoded plus 3 tail symbols, no errors -> c_out reproduces the pattern LSB first; first out_valid K+4 cycles after last-symbol edge; final_metric=0.
3. Same stream with z_in inverted at symbol 10 -> identical decoded bits; final_metric=1.
4. Same stream with in_valid toggling 1,0,1,0 and start pulsed again mid-block -> output identical to scenario 2; the extra start has no effect.
5. aclr asserted after 20 symbols -> busy=0 and out_valid=0 immediately; a fresh start plus scenario 2 stream decodes correctly.
6. Scenario 2 stream with x_in inverted on tail symbol 41 -> info bits still correct; final_metric=1; no out_valid for tail steps.
